// File: rtl/dsp_top.sv
// Iterative signed multiply / shift / accumulate unit with a variable-depth output pipeline.
// Optional product barrel shifter is enabled with the DSP_SHIFT_EN macro.
module dsp_top #(
    parameter int WIDTH            = 16,
    parameter int PPM_TYPE         = 0,
    parameter int SHIFT_BITS       = 2,
    parameter int PIPE_STAGE_WIDTH = 2,
    parameter int PIPELINE_BITS    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [WIDTH-1:0]            aa,
    input  logic [WIDTH-1:0]            bb,
    input  logic [2*WIDTH-1:0]          cc,
    input  logic                        mac,
    input  logic [SHIFT_BITS-1:0]       shift_amount,
    input  logic                        shift_dir,
    input  logic [PIPE_STAGE_WIDTH-1:0] pipe_stages,
    output logic [2*WIDTH-1:0]          out
);

    localparam int H    = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam int MAXP = (2 ** PIPELINE_BITS) - 1;
    localparam int NB   = (H + 2) / 2;
    localparam int BL   = 2 * NB;

    typedef enum logic {S_IDLE, S_ITER} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0]         a_q, b_q;
    logic [PW-1:0]            c_q;
    logic [1:0]               mode_q;
    logic                     mac_q;
    logic [PIPELINE_BITS-1:0] p_q, p_cap;
    logic [1:0]               idx, n_last;
    logic [PW-1:0]            acc;
    logic                     accept, last_iter;

    logic [H:0]               core_a, core_b;
    logic                     a_hi, b_hi;
    logic [PW-1:0]            ax_e, core_p, part, prod, sprod, res_direct;

    logic [PW-1:0]            pl_sp  [MAXP];
    logic [PW-1:0]            pl_c   [MAXP];
    logic [MAXP-1:0]          pl_mac, pl_v;

    // Select core operands: low halves are zero-extended, high halves sign-extended.
    always_comb begin
        core_a = '0;
        core_b = '0;
        a_hi   = 1'b0;
        b_hi   = 1'b0;
        if (mode_q == 2'd0) begin
            core_a = a_q[H:0];
            core_b = b_q[H:0];
        end else if (mode_q == 2'd1) begin
            b_hi   = idx[0];
            core_a = a_q[H:0];
            core_b = b_hi ? {b_q[WIDTH-1], b_q[WIDTH-1:H]} : {1'b0, b_q[H-1:0]};
        end else begin
            a_hi   = idx[1];
            b_hi   = idx[0];
            core_a = a_hi ? {a_q[WIDTH-1], a_q[WIDTH-1:H]} : {1'b0, a_q[H-1:0]};
            core_b = b_hi ? {b_q[WIDTH-1], b_q[WIDTH-1:H]} : {1'b0, b_q[H-1:0]};
        end
    end

    assign ax_e = PW'($signed(core_a));

    generate
        if (PPM_TYPE == 0) begin : g_booth
            logic [BL:0] bx;
            logic [2:0]  trip;
            assign bx = {BL'($signed(core_b)), 1'b0};
            always_comb begin
                core_p = '0;
                trip   = '0;
                for (int unsigned i = 0; i < NB; i++) begin
                    trip = bx[2*i +: 3];
                    case (trip)
                        3'b001, 3'b010: core_p = core_p + (ax_e << (2*i));
                        3'b011:         core_p = core_p + (ax_e << (2*i + 1));
                        3'b100:         core_p = core_p - (ax_e << (2*i + 1));
                        3'b101, 3'b110: core_p = core_p - (ax_e << (2*i));
                        default:        core_p = core_p;
                    endcase
                end
            end
        end else begin : g_array
            always_comb begin
                core_p = '0;
                for (int unsigned j = 0; j <= H; j++) begin
                    if (core_b[j]) begin
                        // The top bit of a signed multiplier carries negative weight.
                        if (j == H) core_p = core_p - (ax_e << j);
                        else        core_p = core_p + (ax_e << j);
                    end
                end
            end
        end
    endgenerate

    assign part = core_p << (H * (int'(a_hi) + int'(b_hi)));
    assign prod = acc + part;

`ifdef DSP_SHIFT_EN
    logic [SHIFT_BITS-1:0] sa_q;
    logic                  sd_q;
    assign sprod = sd_q ? PW'($signed(prod) >>> sa_q) : (prod << sa_q);
`else
    logic unused_shift;
    assign unused_shift = ^{shift_amount, shift_dir};
    assign sprod = prod;
`endif

    assign res_direct = sprod + (mac_q ? out : c_q);

    always_comb begin
        if (32'(pipe_stages) > 32'(MAXP)) p_cap = PIPELINE_BITS'(MAXP);
        else                               p_cap = PIPELINE_BITS'(pipe_stages);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_ITER;
            S_ITER:  if (last_iter && !accept) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        case (mode_q)
            2'd0:    n_last = 2'd0;
            2'd1:    n_last = 2'd1;
            default: n_last = 2'd3;
        endcase
        last_iter = (state == S_ITER) && (idx == n_last);
        accept    = start && ((state == S_IDLE) || last_iter);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            mode_q <= '0;
            mac_q  <= 1'b0;
            p_q    <= '0;
            idx    <= '0;
            acc    <= '0;
            out    <= '0;
            pl_v   <= '0;
            pl_mac <= '0;
            for (int unsigned i = 0; i < MAXP; i++) begin
                pl_sp[i] <= '0;
                pl_c[i]  <= '0;
            end
`ifdef DSP_SHIFT_EN
            sa_q <= '0;
            sd_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_q    <= aa;
                b_q    <= bb;
                c_q    <= cc;
                mode_q <= mode;
                mac_q  <= mac;
                p_q    <= p_cap;
                idx    <= '0;
                acc    <= '0;
`ifdef DSP_SHIFT_EN
                sa_q <= shift_amount;
                sd_q <= shift_dir;
`endif
            end else if (state == S_ITER) begin
                idx <= idx + 2'd1;
                acc <= prod;
            end

            for (int unsigned i = 0; i + 1 < MAXP; i++) begin
                pl_sp[i]  <= pl_sp[i+1];
                pl_c[i]   <= pl_c[i+1];
                pl_mac[i] <= pl_mac[i+1];
                pl_v[i]   <= pl_v[i+1];
            end
            pl_v[MAXP-1] <= 1'b0;

            // Enter the pipeline p-1 slots from the end so the result retires p edges later.
            if (last_iter && (p_q != '0)) begin
                for (int unsigned i = 0; i < MAXP; i++) begin
                    if (32'(p_q) == i + 1) begin
                        pl_sp[i]  <= sprod;
                        pl_c[i]   <= c_q;
                        pl_mac[i] <= mac_q;
                        pl_v[i]   <= 1'b1;
                    end
                end
            end

            // Accumulation uses the live out value at the retiring edge.
            if (pl_v[0])
                out <= pl_sp[0] + (pl_mac[0] ? out : pl_c[0]);
            else if (last_iter && (p_q == '0))
                out <= res_direct;
        end
    end

endmodule

// File: tb/tb_dsp_top.sv
// Self-checking bench for dsp_top: directed cases plus randomized operations against
// an event-scheduled arithmetic reference model.
module tb_dsp_top;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst, start, mac, shift_dir;
    logic [1:0]     mode, shift_amount, pipe_stages;
    logic [W-1:0]   aa, bb;
    logic [2*W-1:0] cc, out;

    dsp_top #(
        .WIDTH(W), .PPM_TYPE(0), .SHIFT_BITS(2), .PIPE_STAGE_WIDTH(2), .PIPELINE_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .aa(aa), .bb(bb), .cc(cc),
        .mac(mac), .shift_amount(shift_amount), .shift_dir(shift_dir),
        .pipe_stages(pipe_stages), .out(out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          ret;
        logic [31:0] sp;
        logic [31:0] c;
        bit          mac;
    } op_t;

    op_t         pend[$];
    int          cyc        = 0;
    int          busy_until = 0;
    int          last_ret   = 0;
    logic [31:0] exp_out    = '0;
    bit          chk_on     = 1'b0;

    function automatic int n_of(input logic [1:0] m);
        return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_sp(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] sa, input logic sd);
        longint      p;
        logic [31:0] p32;
        p   = longint'($signed(a)) * longint'($signed(b));
        p32 = p[31:0];
`ifdef DSP_SHIFT_EN
        if (sd) p32 = $signed(p32) >>> sa;
        else    p32 = p32 << sa;
`else
        if (sd && (sa == 2'd3)) p32 = p32;
`endif
        return p32;
    endfunction

    function automatic logic [15:0] sx9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    // Reference: each accepted operation retires at a scheduled cycle.
    always @(posedge clk) begin
        op_t o;
        int  p;
        cyc++;
        if (rst) begin
            pend.delete();
            exp_out    = '0;
            busy_until = 0;
            last_ret   = 0;
        end else begin
            while (pend.size() > 0 && pend[0].ret == cyc) begin
                exp_out = pend[0].sp + (pend[0].mac ? exp_out : pend[0].c);
                void'(pend.pop_front());
            end
            if (start && cyc >= busy_until) begin
                p     = (int'(pipe_stages) > 3) ? 3 : int'(pipe_stages);
                o.ret = cyc + n_of(mode) + p;
                o.sp  = model_sp(aa, bb, shift_amount, shift_dir);
                o.c   = cc;
                o.mac = mac;
                pend.push_back(o);
                busy_until = cyc + n_of(mode);
                last_ret   = o.ret;
            end
        end
    end

    always @(negedge clk) if (chk_on) check_eq("out_model", out, exp_out);

    task automatic issue(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] c, input logic mc, input logic [1:0] sa,
                         input logic sd, input logic [1:0] ps);
        mode = m; aa = a; bb = b; cc = c; mac = mc;
        shift_amount = sa; shift_dir = sd; pipe_stages = ps;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [1:0]  m;
        logic [15:0] a, b;
        int          nn, ps, gap;

        rst = 1'b1; start = 1'b0; mode = '0; aa = '0; bb = '0; cc = '0; mac = 1'b0;
        shift_amount = '0; shift_dir = 1'b0; pipe_stages = '0;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset", out, 32'h0);
        rst = 1'b0;

        issue(2'd0, 16'hFFFD, 16'h0005, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
        @(negedge clk);
        check_eq("m0_neg", out, 32'hFFFFFFF1);

        issue(2'd2, 16'h7FFF, 16'h8000, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
        aa = 16'h0001; mode = 2'd0; start = 1'b1;   // ignored: core busy
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("m2_pending", out, 32'hFFFFFFF1);
        issue(2'd0, 16'h0003, 16'h0004, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
        check_eq("m2_full", out, 32'hC0008000);
        @(negedge clk);
        check_eq("m2_b2b", out, 32'd12);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(2'd0, 16'd5, 16'd1, 32'h0, 1'b1, 2'd0, 1'b0, 2'd0);
        issue(2'd0, 16'd7, 16'd1, 32'h0, 1'b1, 2'd0, 1'b0, 2'd0);
        check_eq("mac_1", out, 32'd5);
        issue(2'd0, 16'hFFFE, 16'd1, 32'h0, 1'b1, 2'd0, 1'b0, 2'd0);
        check_eq("mac_2", out, 32'd12);
        @(negedge clk);
        check_eq("mac_3", out, 32'd10);

        issue(2'd1, 16'h0002, 16'h1234, 32'h0, 1'b0, 2'd0, 1'b0, 2'd1);
        repeat (2) @(negedge clk);
        check_eq("m1_hold", out, 32'd10);
        @(negedge clk);
        check_eq("m1_pipe", out, 32'h00002468);

`ifdef DSP_SHIFT_EN
        issue(2'd0, 16'd3, 16'd4, 32'h0, 1'b0, 2'd2, 1'b0, 2'd0);
        @(negedge clk);
        check_eq("shl", out, 32'd48);
        issue(2'd0, 16'd3, 16'd4, 32'h0, 1'b0, 2'd2, 1'b1, 2'd0);
        @(negedge clk);
        check_eq("sar", out, 32'd3);
`else
        issue(2'd0, 16'd3, 16'd4, 32'h0, 1'b0, 2'd2, 1'b1, 2'd0);
        @(negedge clk);
        check_eq("noshift", out, 32'd12);
`endif

        issue(2'd2, 16'h1234, 16'h5678, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_rst", out, 32'h0);
        repeat (2) @(negedge clk);
        check_eq("abort_none", out, 32'h0);

        rst = 1'b1; start = 1'b1; mode = 2'd0; aa = 16'd5; bb = 16'd5; mac = 1'b0; cc = '0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_prio", out, 32'h0);

        for (int n = 0; n < 200; n++) begin
            while (cyc + 1 < busy_until) begin
                if ($urandom_range(0, 3) == 0) begin
                    start = 1'b1; aa = 16'($urandom); mode = 2'($urandom); pipe_stages = '0;
                end
                @(negedge clk);
                start = 1'b0;
            end
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            m = 2'($urandom);
            if (m == 2'd0) begin
                a = sx9(9'($urandom)); b = sx9(9'($urandom));
            end else if (m == 2'd1) begin
                a = sx9(9'($urandom)); b = 16'($urandom);
            end else begin
                a = 16'($urandom); b = 16'($urandom);
            end
            nn = n_of(m);
            ps = $urandom_range(0, 3);
            if (cyc + 1 + nn + ps <= last_ret) ps = last_ret - (cyc + 1 + nn) + 1;
            issue(m, a, b, $urandom, 1'($urandom), 2'($urandom), 1'($urandom), 2'(ps));
        end

        repeat (10) @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
